// File: rtl/bsg_tx_scheduler.sv
// bsg_tx_scheduler: round-robin arbiter between two byte producers that
// frames each accepted byte as start/8 data/stop symbols for the sine-table
// modulator. Symbol edges are aligned to the modulator's phase wrap.
module bsg_tx_scheduler #(
   parameter int   SYM_REPEAT = 1,
   parameter logic IDLE_BIT   = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_req0_valid,
   input  logic [7:0] i_req0_data,
   output logic       o_req0_ready,
   input  logic       i_req1_valid,
   input  logic [7:0] i_req1_data,
   output logic       o_req1_ready,
   output logic [4:0] o_mod_phase,
   output logic       o_mod_bit,
   output logic       o_mod_en,
   output logic       o_grant_id,
   output logic       o_busy
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_t;

   localparam logic [3:0] REP_LAST = 4'(SYM_REPEAT - 1);

   logic [4:0] r_phase;
   logic [3:0] r_rep;
   txState_t   r_state;
   logic [7:0] r_shift;
   logic [2:0] r_bitIdx;
   logic       r_lastGrant;
   logic       r_grantId;
   logic       r_modBit;
   logic       r_modEn;

   logic       w_symBoundary;
   logic       w_acceptWindow;
   logic       w_anyValid;
   logic       w_grant;
   logic       w_accept;
   txState_t   w_nextState;
   logic [7:0] w_nextShift;
   logic [2:0] w_nextBitIdx;
   logic       w_nextModBit;
   logic       w_nextModEn;

   // Free-running sample phase plus the repeat count that stretches a symbol.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_phase <= 5'd0;
         r_rep   <= 4'd0;
      end else begin
         r_phase <= r_phase + 5'd1;
         if (r_phase == 5'd31) begin
            r_rep <= (r_rep == REP_LAST) ? 4'd0 : r_rep + 4'd1;
         end
      end
   end

   assign w_symBoundary  = (r_phase == 5'd31) && (r_rep == REP_LAST);
   assign w_acceptWindow = w_symBoundary && ((r_state == IDLE) || (r_state == STOP));
   assign w_anyValid     = i_req0_valid || i_req1_valid;
   assign w_grant        = (i_req0_valid && i_req1_valid) ? ~r_lastGrant : i_req1_valid;
   assign w_accept       = w_acceptWindow && w_anyValid;

   assign o_req0_ready   = w_accept && i_req0_valid && !w_grant;
   assign o_req1_ready   = w_accept && i_req1_valid && w_grant;

   // Frame sequencing on symbol boundaries and the next value of the modulator outputs.
   always_comb begin
      w_nextState  = r_state;
      w_nextShift  = r_shift;
      w_nextBitIdx = r_bitIdx;
      w_nextModBit = IDLE_BIT;
      w_nextModEn  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_nextState = START;
               w_nextShift = w_grant ? i_req1_data : i_req0_data;
            end
         end
         START: begin
            if (w_symBoundary) begin
               w_nextState  = DATA;
               w_nextBitIdx = 3'd0;
            end
         end
         DATA: begin
            if (w_symBoundary) begin
               w_nextShift  = {1'b0, r_shift[7:1]};
               w_nextBitIdx = r_bitIdx + 3'd1;
               if (r_bitIdx == 3'd7) begin
                  w_nextState = STOP;
               end
            end
         end
         STOP: begin
            if (w_symBoundary) begin
               if (w_accept) begin
                  w_nextState = START;
                  w_nextShift = w_grant ? i_req1_data : i_req0_data;
               end else begin
                  w_nextState = IDLE;
               end
            end
         end
         default: w_nextState = IDLE;
      endcase
      case (w_nextState)
         START: begin
            w_nextModBit = 1'b0;
            w_nextModEn  = 1'b1;
         end
         DATA: begin
            w_nextModBit = w_nextShift[0];
            w_nextModEn  = 1'b1;
         end
         STOP: begin
            w_nextModBit = IDLE_BIT;
            w_nextModEn  = 1'b1;
         end
         default: begin
            w_nextModBit = IDLE_BIT;
            w_nextModEn  = 1'b0;
         end
      endcase
   end

   // Registered frame state, arbitration history and modulator outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_shift     <= 8'd0;
         r_bitIdx    <= 3'd0;
         r_lastGrant <= 1'b1;
         r_grantId   <= 1'b0;
         r_modBit    <= IDLE_BIT;
         r_modEn     <= 1'b0;
      end else begin
         r_state  <= w_nextState;
         r_shift  <= w_nextShift;
         r_bitIdx <= w_nextBitIdx;
         r_modBit <= w_nextModBit;
         r_modEn  <= w_nextModEn;
         if (w_accept) begin
            r_lastGrant <= w_grant;
            r_grantId   <= w_grant;
         end
      end
   end

   assign o_mod_phase = r_phase;
   assign o_mod_bit   = r_modBit;
   assign o_mod_en    = r_modEn;
   assign o_busy      = r_modEn;
   assign o_grant_id  = r_grantId;

endmodule

// File: tb/tb_bsg_tx_scheduler.sv
// tb_bsg_tx_scheduler: drives two scheduler instances (1 and 3 phase periods
// per symbol) and compares them every cycle against a frame-timeline model.
module tb_bsg_tx_scheduler;

   logic       clk;
   logic       reset;
   logic [1:0] v0;
   logic [1:0] v1;
   logic [7:0] d0 [2];
   logic [7:0] d1 [2];
   logic [1:0] rdy0;
   logic [1:0] rdy1;
   logic [1:0] bitBus;
   logic [1:0] enBus;
   logic [1:0] gntBus;
   logic [1:0] busyBus;
   logic [9:0] phBus;

   int nChecks = 0;
   int nErrors = 0;

   int         mT      [2];
   bit         mActive [2];
   int         mStart  [2];
   logic [7:0] mByte   [2];
   bit         mLast   [2];
   bit         mGrant  [2];

   bsg_tx_scheduler #(.SYM_REPEAT(1), .IDLE_BIT(1'b1)) dut0 (
      .clk(clk), .reset(reset),
      .i_req0_valid(v0[0]), .i_req0_data(d0[0]), .o_req0_ready(rdy0[0]),
      .i_req1_valid(v1[0]), .i_req1_data(d1[0]), .o_req1_ready(rdy1[0]),
      .o_mod_phase(phBus[4:0]), .o_mod_bit(bitBus[0]), .o_mod_en(enBus[0]),
      .o_grant_id(gntBus[0]), .o_busy(busyBus[0])
   );

   bsg_tx_scheduler #(.SYM_REPEAT(3), .IDLE_BIT(1'b1)) dut1 (
      .clk(clk), .reset(reset),
      .i_req0_valid(v0[1]), .i_req0_data(d0[1]), .o_req0_ready(rdy0[1]),
      .i_req1_valid(v1[1]), .i_req1_data(d1[1]), .o_req1_ready(rdy1[1]),
      .o_mod_phase(phBus[9:5]), .o_mod_bit(bitBus[1]), .o_mod_en(enBus[1]),
      .o_grant_id(gntBus[1]), .o_busy(busyBus[1])
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int repOf(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic int phaseOf(input int i);
      return (i == 0) ? int'(phBus[4:0]) : int'(phBus[9:5]);
   endfunction

   function automatic bit mWindow(input int i);
      int p;
      bit sb;
      bit onStop;
      p      = 32 * repOf(i);
      sb     = (mT[i] % p) == (p - 1);
      onStop = mActive[i] && (((mT[i] - mStart[i]) / p) == 9);
      return sb && (!mActive[i] || onStop);
   endfunction

   function automatic bit mPick(input int i);
      if (v0[i] && v1[i]) return !mLast[i];
      return v1[i];
   endfunction

   function automatic bit mBitExp(input int i);
      int p;
      int k;
      if (!mActive[i]) return 1'b1;
      p = 32 * repOf(i);
      k = (mT[i] - mStart[i]) / p;
      if (k == 0) return 1'b0;
      if (k <= 8) return mByte[i][k-1];
      return 1'b1;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      nChecks++;
      if (actual != expected) begin
         nErrors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: a timeline of frames, each 10 symbols from its start cycle.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 2; i++) begin
            mT[i] = 0; mActive[i] = 1'b0; mStart[i] = 0;
            mByte[i] = 8'd0; mLast[i] = 1'b1; mGrant[i] = 1'b0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            int p;
            bit g;
            p = 32 * repOf(i);
            if (mWindow(i) && (v0[i] || v1[i])) begin
               g          = mPick(i);
               mLast[i]   = g;
               mGrant[i]  = g;
               mByte[i]   = g ? d1[i] : d0[i];
               mActive[i] = 1'b1;
               mStart[i]  = mT[i] + 1;
            end else if (mActive[i] && (mT[i] + 1 == mStart[i] + 10 * p)) begin
               mActive[i] = 1'b0;
            end
            mT[i] = mT[i] + 1;
         end
      end
   end

   // Per-cycle comparison of both instances against the model.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("phase%0d", i), phaseOf(i), mT[i] % 32);
            checkOutput($sformatf("bit%0d", i), int'(bitBus[i]), int'(mBitExp(i)));
            checkOutput($sformatf("en%0d", i), int'(enBus[i]), int'(mActive[i]));
            checkOutput($sformatf("busy%0d", i), int'(busyBus[i]), int'(mActive[i]));
            checkOutput($sformatf("grant%0d", i), int'(gntBus[i]), int'(mGrant[i]));
            checkOutput($sformatf("ready0_%0d", i), int'(rdy0[i]),
                        int'(mWindow(i) && v0[i] && !mPick(i)));
            checkOutput($sformatf("ready1_%0d", i), int'(rdy1[i]),
                        int'(mWindow(i) && v1[i] && mPick(i)));
         end
      end
   end

   // Hard time limit so the run always ends.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input logic [1:0] valid0, input logic [1:0] valid1);
      v0 = valid0;
      v1 = valid1;
   endtask

   task automatic runSingle();
      int         readyCnt [2];
      int         readyPh  [2];
      int         enCnt    [2];
      logic [9:0] bits     [2];
      int         edgeBad  [2];
      logic       prevBit  [2];
      bit         done     [2];
      int         n;
      for (int i = 0; i < 2; i++) begin
         readyCnt[i] = 0; readyPh[i] = -1; enCnt[i] = 0; bits[i] = 10'd0;
         edgeBad[i] = 0; prevBit[i] = 1'b1; done[i] = 1'b0;
      end
      @(negedge clk);
      d0[0] = 8'hA5;
      d0[1] = 8'h01;
      applyStimulus(2'b11, 2'b00);
      n = 0;
      while (!(done[0] && done[1]) && n < 32 * 3 * 14) begin
         #1;
         for (int i = 0; i < 2; i++) begin
            int p;
            p = 32 * repOf(i);
            if (rdy0[i]) begin
               readyCnt[i]++;
               readyPh[i] = phaseOf(i);
            end
            if (n > 0 && bitBus[i] != prevBit[i] && phaseOf(i) != 0) edgeBad[i]++;
            prevBit[i] = bitBus[i];
            if (enBus[i]) begin
               if ((enCnt[i] % p) == p / 2 && (enCnt[i] / p) < 10) bits[i][enCnt[i]/p] = bitBus[i];
               enCnt[i]++;
            end else if (enCnt[i] > 0) begin
               done[i] = 1'b1;
            end
         end
         @(negedge clk);
         n++;
         for (int i = 0; i < 2; i++) begin
            if (readyCnt[i] > 0) v0[i] = 1'b0;
         end
      end
      for (int i = 0; i < 2; i++) begin
         checkOutput($sformatf("single_done%0d", i), int'(done[i]), 1);
         checkOutput($sformatf("single_readyCount%0d", i), readyCnt[i], 1);
         checkOutput($sformatf("single_readyPhase%0d", i), readyPh[i], 31);
         checkOutput($sformatf("single_enCycles%0d", i), enCnt[i], 320 * repOf(i));
         checkOutput($sformatf("single_midEdges%0d", i), edgeBad[i], 0);
      end
      checkOutput("single_bits0", int'(bits[0]), int'(10'b1101001010));
      checkOutput("single_bits1", int'(bits[1]), int'(10'b1000000010));
      #1;
      checkOutput("single_idleBit0", int'(bitBus[0]), 1);
   endtask

   task automatic runTie();
      int         acc;
      logic [3:0] seq;
      logic [3:0] gseq;
      int         badPhase;
      int         gapCycles;
      bit         seenEn;
      bit         pending;
      int         pendIdx;
      int         n;
      acc = 0; seq = 4'd0; gseq = 4'd0; badPhase = 0; gapCycles = 0;
      seenEn = 1'b0; pending = 1'b0; pendIdx = 0; n = 0;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         d0[i] = 8'h00;
         d1[i] = 8'hFF;
      end
      applyStimulus(2'b11, 2'b11);
      while (acc < 4 && n < 2000) begin
         #1;
         if (pending) begin
            gseq[pendIdx] = gntBus[0];
            pending = 1'b0;
         end
         if (rdy0[0] || rdy1[0]) begin
            seq[acc] = rdy1[0];
            if (phaseOf(0) != 31) badPhase++;
            pendIdx = acc;
            pending = 1'b1;
            acc++;
         end
         if ((rdy0[1] || rdy1[1]) && phaseOf(1) != 31) badPhase++;
         if (seenEn && !enBus[0]) gapCycles++;
         if (enBus[0]) seenEn = 1'b1;
         @(negedge clk);
         n++;
      end
      #1;
      if (pending) gseq[pendIdx] = gntBus[0];
      checkOutput("tie_accepts", acc, 4);
      checkOutput("tie_readyOrder", int'(seq), int'(4'b1010));
      checkOutput("tie_grantId", int'(gseq), int'(4'b1010));
      checkOutput("tie_readyOffBoundary", badPhase, 0);
      checkOutput("tie_idleGap", gapCycles, 0);
      @(negedge clk);
      applyStimulus(2'b00, 2'b00);
   endtask

   task automatic runResetMid();
      int n;
      int enEarly;
      int readyAt;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      d1[0] = 8'h3C;
      applyStimulus(2'b00, 2'b01);
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (!enBus[0] && n < 200);
      checkOutput("mid_frameStarted", int'(enBus[0]), 1);
      repeat (170) @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("mid_resetEn", int'(enBus[0]), 0);
      checkOutput("mid_resetBit", int'(bitBus[0]), 1);
      checkOutput("mid_resetPhase", phaseOf(0), 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      n = 0; enEarly = 0; readyAt = -1;
      while (readyAt < 0 && n < 100) begin
         #1;
         if (rdy1[0]) readyAt = n;
         else if (enBus[0]) enEarly++;
         @(negedge clk);
         n++;
      end
      checkOutput("mid_reacceptCycle", readyAt, 31);
      checkOutput("mid_residualFrame", enEarly, 0);
      applyStimulus(2'b00, 2'b00);
   endtask

   task automatic runRandom(input int cycles);
      bit seen0 [2];
      bit seen1 [2];
      for (int i = 0; i < 2; i++) begin
         seen0[i] = 1'b0;
         seen1[i] = 1'b0;
      end
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (v0[i] && seen0[i]) begin
               v0[i] = ($urandom_range(1, 0) == 1);
               d0[i] = 8'($urandom);
            end else if (v0[i]) begin
               if ($urandom_range(199, 0) == 0) v0[i] = 1'b0;
            end else if ($urandom_range(39, 0) == 0) begin
               v0[i] = 1'b1;
               d0[i] = 8'($urandom);
            end
            if (v1[i] && seen1[i]) begin
               v1[i] = ($urandom_range(1, 0) == 1);
               d1[i] = 8'($urandom);
            end else if (v1[i]) begin
               if ($urandom_range(199, 0) == 0) v1[i] = 1'b0;
            end else if ($urandom_range(39, 0) == 0) begin
               v1[i] = 1'b1;
               d1[i] = 8'($urandom);
            end
         end
         #1;
         for (int i = 0; i < 2; i++) begin
            seen0[i] = rdy0[i];
            seen1[i] = rdy1[i];
         end
      end
   endtask

   // Directed scenarios followed by randomized traffic.
   initial begin
      int dropReady;
      int dropEn;
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         d0[i] = 8'd0;
         d1[i] = 8'd0;
      end
      applyStimulus(2'b00, 2'b00);
      #1 reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (13) @(negedge clk);

      reset = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         checkOutput($sformatf("rst_phase%0d", i), phaseOf(i), 0);
         checkOutput($sformatf("rst_en%0d", i), int'(enBus[i]), 0);
         checkOutput($sformatf("rst_bit%0d", i), int'(bitBus[i]), 1);
         checkOutput($sformatf("rst_grant%0d", i), int'(gntBus[i]), 0);
         checkOutput($sformatf("rst_ready%0d", i), int'(rdy0[i] | rdy1[i]), 0);
      end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         checkOutput($sformatf("rst_resume%0d", k), phaseOf(0), k);
         @(negedge clk);
      end

      d1[0] = 8'h5A;
      d1[1] = 8'h5A;
      dropReady = 0;
      dropEn = 0;
      repeat (2) @(negedge clk);
      for (int c = 0; c < 115; c++) begin
         if (c == 0) applyStimulus(2'b00, 2'b11);
         if (c == 5) applyStimulus(2'b00, 2'b00);
         #1;
         dropReady += int'(rdy0[0]) + int'(rdy1[0]) + int'(rdy0[1]) + int'(rdy1[1]);
         dropEn += int'(enBus[0]) + int'(enBus[1]);
         @(negedge clk);
      end
      checkOutput("drop_ready", dropReady, 0);
      checkOutput("drop_frame", dropEn, 0);

      runSingle();
      runTie();
      runResetMid();
      runRandom(4000);
      @(negedge clk);
      applyStimulus(2'b00, 2'b00);
      repeat (10) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
      $finish;
   end

endmodule

// File: doc/bsg_tx_scheduler.md
# bsg_tx_scheduler

Frame scheduler and two-requester arbiter in front of the BSG sine-table modulator. Accepts bytes from two producers over valid/ready handshakes and selects one producer per frame by round robin. Serializes each byte as a start/data/stop symbol frame and drives the modulator's data bit and 5-bit sample phase, so that bit changes land only on symbol boundaries (phase wrap 31→0).

## Interface
- SYM_REPEAT, default 1: number of 32-sample phase periods per symbol; legal range 1..16.
- IDLE_BIT, default 1: value driven on mod_bit while idle and during the stop symbol.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low.
- req0_valid  in  1  requester 0 has a byte.
- req0_data  in  8  requester 0 byte; must be stable while req0_valid is high and unaccepted.
- req0_ready  out  1  one-cycle accept strobe for requester 0.
- req1_valid / req1_data / req1_ready: same as the req0 signals, for requester 1.
- mod_phase  out  5  sample index to the modulator; free-running 0..31.
- mod_bit  out  1  symbol bit to the modulator.
- mod_en  out  1  high while a frame is on air.
- grant_id  out  1  requester owning the current or most recent frame.
- busy  out  1  equals mod_en.

## Operation
- **Phase counter:** mod_phase increments every clk and wraps 31→0.
- **Repeat counter:** rep (4 bits) increments on each phase wrap and wraps at SYM_REPEAT-1.
- **Symbol boundary (sb):** mod_phase==31 and rep==SYM_REPEAT-1.
- **FSM states:** IDLE, START, DATA, STOP. Bit index bi is 3 bits; a shift register holds the byte.
  - IDLE: mod_bit=IDLE_BIT, mod_en=0. On sb with any valid: arbitrate, accept, then START.
  - START: mod_bit=0. On sb: go to DATA with bi=0.
  - DATA: mod_bit=shift[0] (LSB first). On sb: shift right and increment bi. On sb with bi==7: go to STOP.
  - STOP: mod_bit=IDLE_BIT. On sb with any valid: arbitrate, accept, then START (back-to-back frames with no idle gap). On sb with no valid: go to IDLE.
- **Arbitration** happens only in an accept window: sb in IDLE or STOP.
  - Only one valid: grant that requester.
  - Both valid: grant the requester not equal to last_grant.
  - last_grant and grant_id update on accept.
- **Ready:** reqN_ready = accept window & reqN_valid & (granted==N). It is high for exactly that one cycle. The byte is latched from reqN_data in that cycle.
- **Losing requester:** keeps valid asserted. It is served at the next accept window.
- **Valid dropping:** a valid that drops before its window is ignored, with no error.
- **Reset mid-operation:** all state returns to reset values immediately. The in-flight frame is aborted and never resent.

## Timing
- **Reset values:** mod_phase=0, rep=0, state IDLE, mod_bit=IDLE_BIT, mod_en=0, busy=0, grant_id=0, req0_ready=0, req1_ready=0, last_grant=1 (so req0 wins the first tie).
- **Accept-to-air latency:** the accept occurs at phase 31 of the window. In the next cycle, mod_phase=0, state=START, mod_bit=0, mod_en=1.
- **Symbol length:** 32·SYM_REPEAT cycles.
- **Frame length:** 10 symbols (320 cycles at SYM_REPEAT=1).
- **Wait from IDLE:** a valid raised in IDLE waits up to 32·SYM_REPEAT cycles for the next sb.
- **Output registration:** mod_bit and mod_en are registered and change only in the cycle where mod_phase becomes 0 after a sb. They never change mid-symbol.
- **Ready timing:** ready is combinational from registered state and the valid inputs. There is no combinational path from req*_data to any output.

## Test plan
- **Reset values:** assert reset for 3 cycles at an arbitrary phase -> all outputs at reset values. mod_phase resumes 0,1,2… after release.
- **Single byte:** req0 sends 0xA5 at SYM_REPEAT=1 -> req0_ready pulses once at phase 31. mod_bit then reads 0,1,0,1,0,0,1,0,1,1, each held exactly 32 cycles, with mod_en high for 320 cycles. Afterwards state is IDLE with mod_bit=1.
- **Tie and round robin:** req0=0x00 and req1=0xFF both valid and held -> frames are granted 0,1,0,1 in turn. Frames run back to back with no idle symbol. grant_id tracks the frame owner, and no ready fires outside an sb cycle.
- **SYM_REPEAT=3:** single byte 0x01 -> each symbol lasts 96 cycles. The data bits read 1,0,0,0,0,0,0,0, and mod_bit edges coincide with mod_phase=0.
- **Reset mid-frame:** reset asserted during DATA bit 4 -> mod_en=0 and mod_bit=1 asynchronously. After release, no residual frame appears, and a still-asserted req1 is accepted at the first sb.
- **Dropped request:** req1_valid pulses for 5 cycles mid-symbol in IDLE, then drops -> no ready and no frame.
